// File: rtl/morse_player.sv
// Morse symbol player: plays up to MAX_LEN dot/dash symbols with unit-timed
// marks and gaps, single clock domain, registered LED/handshake outputs.
module morse_player #(
    parameter int unsigned MAX_LEN     = 4,
    parameter int unsigned UNIT_CYCLES = 1000,
    parameter int unsigned DASH_UNITS  = 3,
    parameter int unsigned GAP_UNITS   = 1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               start_i,
    input  logic [MAX_LEN-1:0]                 code_i,
    input  logic [$clog2(MAX_LEN+1)-1:0]       length_i,
    input  logic                               abort_i,
    output logic                               ready_o,
    output logic                               busy_o,
    output logic                               dotLed_o,
    output logic                               dashLed_o,
    output logic                               doneLed_o
);

    localparam int unsigned LW   = $clog2(MAX_LEN + 1);
    localparam int unsigned MAXU = (DASH_UNITS > GAP_UNITS) ? DASH_UNITS : GAP_UNITS;
    localparam int unsigned TW   = $clog2(MAXU * UNIT_CYCLES + 1);

    localparam logic [TW-1:0] DOT_LD  = TW'(UNIT_CYCLES - 1);
    localparam logic [TW-1:0] DASH_LD = TW'(DASH_UNITS * UNIT_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LD  = TW'(GAP_UNITS * UNIT_CYCLES - 1);
    localparam logic [LW-1:0] MAX_LW  = LW'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, MARK, GAP} state_e;

    state_e               state_q, state_d;
    logic [MAX_LEN-1:0]   sr_q, sr_d;
    logic [LW-1:0]        rem_q, rem_d;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 dot_q, dot_d;
    logic                 dash_q, dash_d;
    logic                 done_q, done_d;
    logic [LW-1:0]        len_clamp;

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        rem_d     = rem_q;
        tmr_d     = tmr_q;
        done_d    = done_q;
        len_clamp = (length_i > MAX_LW) ? MAX_LW : length_i;

        case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    sr_d   = code_i;
                    rem_d  = len_clamp;
                    done_d = (len_clamp == '0);
                    if (len_clamp != '0) begin
                        state_d = MARK;
                        tmr_d   = code_i[0] ? DASH_LD : DOT_LD;
                    end
                end
            end
            MARK: begin
                if (abort_i) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                    rem_d   = '0;
                    tmr_d   = '0;
                end else if (tmr_q == '0) begin
                    sr_d  = sr_q >> 1;
                    rem_d = rem_q - LW'(1);
                    if (rem_q == LW'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = GAP;
                        tmr_d   = GAP_LD;
                    end
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            GAP: begin
                if (abort_i) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                    rem_d   = '0;
                    tmr_d   = '0;
                end else if (tmr_q == '0) begin
                    state_d = MARK;
                    tmr_d   = sr_q[0] ? DASH_LD : DOT_LD;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they line up with it once registered.
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        dot_d   = (state_d == MARK) && !sr_d[0];
        dash_d  = (state_d == MARK) && sr_d[0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sr_q    <= '0;
            rem_q   <= '0;
            tmr_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            dot_q   <= 1'b0;
            dash_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            rem_q   <= rem_d;
            tmr_q   <= tmr_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            dot_q   <= dot_d;
            dash_q  <= dash_d;
            done_q  <= done_d;
        end
    end

    assign ready_o   = ready_q;
    assign busy_o    = busy_q;
    assign dotLed_o  = dot_q;
    assign dashLed_o = dash_q;
    assign doneLed_o = done_q;

endmodule

// File: tb/tb_morse_player.sv
// Scoreboard bench for morse_player: stimulus queues per-cycle expected
// output vectors {ready,busy,dot,dash,done}; a negedge monitor compares them.
module tb_morse_player;

    logic       clk;
    logic       rst_ni;
    logic       start_i;
    logic [3:0] code_i;
    logic [2:0] length_i;
    logic       abort_i;
    logic       ready_o, busy_o, dotLed_o, dashLed_o, doneLed_o;

    morse_player #(
        .MAX_LEN    (4),
        .UNIT_CYCLES(4),
        .DASH_UNITS (3),
        .GAP_UNITS  (1)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .code_i   (code_i),
        .length_i (length_i),
        .abort_i  (abort_i),
        .ready_o  (ready_o),
        .busy_o   (busy_o),
        .dotLed_o (dotLed_o),
        .dashLed_o(dashLed_o),
        .doneLed_o(doneLed_o)
    );

    localparam logic [4:0] IDLE_ND = 5'b10000;
    localparam logic [4:0] IDLE_D  = 5'b10001;
    localparam logic [4:0] DOT     = 5'b01100;
    localparam logic [4:0] DASH    = 5'b01010;
    localparam logic [4:0] GAPV    = 5'b01000;

    typedef struct {
        int         cyc;
        logic [4:0] vec;
        string      name;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   b, b2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
            end else if ({ready_o, busy_o, dotLed_o, dashLed_o, doneLed_o} !== e.vec) begin
                errors++;
                $display("FAIL %s @cycle %0d: got rdy/busy/dot/dash/done=%b required %b",
                         e.name, cyc, {ready_o, busy_o, dotLed_o, dashLed_o, doneLed_o}, e.vec);
            end
        end
        if (dotLed_o && dashLed_o) begin
            errors++;
            $display("FAIL led_exclusive @cycle %0d: dot=1 dash=1 required not both", cyc);
        end
    end

    function automatic int mn(int a, int z);
        return (a < z) ? a : z;
    endfunction

    task automatic seg(int a, int z, logic [4:0] v, string n);
        for (int c = a; c <= z; c++) q.push_back('{c, v, n});
    endtask

    // Letter A relative to accept cycle base, truncated after cycle last.
    task automatic push_a(int base, int last);
        seg(base + 1,  mn(base + 4,  last), DOT,    "a_dot");
        seg(base + 5,  mn(base + 8,  last), GAPV,   "a_gap");
        seg(base + 9,  mn(base + 20, last), DASH,   "a_dash");
        seg(base + 21, mn(base + 22, last), IDLE_D, "a_done");
    endtask

    task automatic go(logic [3:0] code, logic [2:0] len);
        start_i  = 1'b1;
        code_i   = code;
        length_i = len;
        @(negedge clk);
        start_i  = 1'b0;
        code_i   = 4'b1010;
        length_i = 3'd5;
    endtask

    task automatic wait_to(int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        rst_ni   = 1'b0;
        start_i  = 1'b0;
        abort_i  = 1'b0;
        code_i   = '0;
        length_i = '0;

        @(negedge clk);
        b = cyc;
        seg(b + 1, b + 2, IDLE_ND, "reset_state");
        wait_to(b + 2);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);

        b = cyc;
        push_a(b, b + 22);
        go(4'b0010, 3'd2);
        wait_to(b + 23);

        b = cyc;
        push_a(b, b + 12);
        seg(b + 13, b + 14, IDLE_ND, "abort_mid_dash");
        go(4'b0010, 3'd2);
        wait_to(b + 12);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        wait_to(b + 14);
        b2 = b + 14;
        push_a(b2, b2 + 22);
        go(4'b0010, 3'd2);
        wait_to(b2 + 23);

        b = cyc;
        seg(b + 1, b + 3, IDLE_D, "abort_start_idle");
        abort_i = 1'b1;
        go(4'b0010, 3'd2);
        abort_i = 1'b0;
        wait_to(b + 4);

        b = cyc;
        push_a(b, b + 3);
        seg(b + 4, b + 5, IDLE_ND, "abort_mid_dot");
        go(4'b0010, 3'd2);
        wait_to(b + 3);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        wait_to(b + 5);

        b = cyc;
        seg(b + 1, b + 3, IDLE_D, "zero_len");
        go(4'b1111, 3'd0);
        wait_to(b + 4);

        b = cyc;
        for (int k = 0; k < 4; k++) begin
            seg(b + 1 + 16 * k, b + 12 + 16 * k, DASH, "clamp_dash");
            if (k < 3) seg(b + 13 + 16 * k, b + 16 + 16 * k, GAPV, "clamp_gap");
        end
        seg(b + 61, b + 62, IDLE_D, "clamp_done");
        go(4'b1111, 3'd7);
        wait_to(b + 63);

        b = cyc;
        push_a(b, b + 22);
        go(4'b0010, 3'd2);
        wait_to(b + 6);
        start_i  = 1'b1;
        code_i   = 4'b1111;
        length_i = 3'd4;
        @(negedge clk);
        start_i  = 1'b0;
        wait_to(b + 23);

        b = cyc;
        push_a(b, b + 20);
        seg(b + 21, b + 22, IDLE_ND, "abort_last_edge");
        go(4'b0010, 3'd2);
        wait_to(b + 20);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        wait_to(b + 23);

        b = cyc;
        push_a(b, b + 10);
        seg(b + 11, b + 16, IDLE_ND, "reset_mid_word");
        go(4'b0010, 3'd2);
        wait_to(b + 10);
        @(posedge clk);
        #1 rst_ni = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        wait_to(b + 17);

        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
